// File: rtl/jtcop_snd_pkg.sv
// jtcop_snd_pkg: shared FSM encoding, ROM base defaults and SDRAM address helper
package jtcop_snd_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic [21:0] CPU_OFFSET_DEF = 22'h0;
    localparam logic [21:0] PCM_OFFSET_DEF = 22'h08000;
    function automatic logic [21:0] sdr_word(input logic [21:0] base, input logic [16:0] word);
        return base + {5'd0, word};
    endfunction
endpackage

// File: rtl/jtcop_snd_romcache.sv
// jtcop_snd_romcache: one-word read cache with tag compare and byte select
module jtcop_snd_romcache #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_data,
    output logic          hit,
    output logic          ok,
    output logic [7:0]    data
);
    logic [AW-2:0] tag;
    logic [15:0]   cache;
    logic          valid;

    assign hit = cs && valid && tag == addr[AW-1:1];

    // ok and data come from the same pre-fill snapshot so they never disagree
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            cache <= '0;
            ok    <= 1'b0;
            data  <= '0;
        end else begin
            if (fill) begin
                valid <= 1'b1;
                tag   <= fill_tag;
                cache <= fill_data;
            end
            ok   <= hit;
            data <= addr[0] ? cache[15:8] : cache[7:0];
        end
    end
endmodule

// File: rtl/jtcop_snd_romarb.sv
// jtcop_snd_romarb: round-robin SDRAM arbiter for sound CPU and ADPCM ROM reads
module jtcop_snd_romarb
    import jtcop_snd_pkg::*;
#(
    parameter logic [21:0] CPU_OFFSET = CPU_OFFSET_DEF,
    parameter logic [21:0] PCM_OFFSET = PCM_OFFSET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cs,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data,
    output logic        cpu_ok,
    input  logic        pcm_cs,
    input  logic [17:0] pcm_addr,
    output logic [7:0]  pcm_data,
    output logic        pcm_ok,
    output logic [21:0] sdr_addr,
    output logic        sdr_rd,
    input  logic        sdr_ack,
    input  logic        sdr_dst,
    input  logic [15:0] sdr_din
);
    state_t      st;
    logic        gnt_pcm, last_pcm;
    logic [16:0] word;
    logic        cpu_hit, pcm_hit;
    logic        cpu_miss, pcm_miss, pick_pcm, fill_cpu, fill_pcm;

    assign cpu_miss = cpu_cs && !cpu_hit;
    assign pcm_miss = pcm_cs && !pcm_hit;
    assign pick_pcm = pcm_miss && (!cpu_miss || !last_pcm);
    assign fill_cpu = st == WAIT && sdr_dst && !gnt_pcm;
    assign fill_pcm = st == WAIT && sdr_dst && gnt_pcm;

    // grant and word are frozen outside IDLE so late address changes never abort a fill
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            sdr_rd   <= 1'b0;
            sdr_addr <= '0;
            gnt_pcm  <= 1'b0;
            last_pcm <= 1'b1;
            word     <= '0;
        end else begin
            case (st)
                IDLE: if (cpu_miss || pcm_miss) begin
                    st       <= REQ;
                    sdr_rd   <= 1'b1;
                    gnt_pcm  <= pick_pcm;
                    last_pcm <= pick_pcm;
                    word     <= pick_pcm ? pcm_addr[17:1] : {2'd0, cpu_addr[15:1]};
                    sdr_addr <= pick_pcm ? sdr_word(PCM_OFFSET, pcm_addr[17:1])
                                         : sdr_word(CPU_OFFSET, {2'd0, cpu_addr[15:1]});
                end
                REQ: if (sdr_ack) begin
                    st     <= WAIT;
                    sdr_rd <= 1'b0;
                end
                WAIT: if (sdr_dst) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    jtcop_snd_romcache #(.AW(16)) u_cpu (
        .clk(clk), .rst(rst), .cs(cpu_cs), .addr(cpu_addr),
        .fill(fill_cpu), .fill_tag(word[14:0]), .fill_data(sdr_din),
        .hit(cpu_hit), .ok(cpu_ok), .data(cpu_data)
    );

    jtcop_snd_romcache #(.AW(18)) u_pcm (
        .clk(clk), .rst(rst), .cs(pcm_cs), .addr(pcm_addr),
        .fill(fill_pcm), .fill_tag(word), .fill_data(sdr_din),
        .hit(pcm_hit), .ok(pcm_ok), .data(pcm_data)
    );
endmodule

// File: tb/tb_jtcop_snd_romarb.sv
// tb_jtcop_snd_romarb: directed scenarios plus randomized traffic against a cache/arbiter model
module tb_jtcop_snd_romarb;
    logic        clk = 0, rst = 1;
    logic        cpu_cs = 0, pcm_cs = 0, sdr_ack = 0, sdr_dst = 0;
    logic [15:0] cpu_addr = 0, sdr_din = 0;
    logic [17:0] pcm_addr = 0;
    logic [7:0]  cpu_data, pcm_data;
    logic        cpu_ok, pcm_ok, sdr_rd;
    logic [21:0] sdr_addr;
    logic        w_pcm_cs = 0;
    logic [17:0] w_pcm_addr = 0;
    logic [7:0]  w_cpu_data, w_pcm_data;
    logic        w_cpu_ok, w_pcm_ok, w_sdr_rd;
    logic [21:0] w_sdr_addr;
    int          n_cmp = 0, n_err = 0;
    logic        mv[2];
    logic [16:0] mt[2];
    logic [15:0] md[2];
    logic        last_pcm;

    always #5 clk = ~clk;

    jtcop_snd_romarb dut (
        .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ok(cpu_ok), .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data),
        .pcm_ok(pcm_ok), .sdr_addr(sdr_addr), .sdr_rd(sdr_rd), .sdr_ack(sdr_ack),
        .sdr_dst(sdr_dst), .sdr_din(sdr_din)
    );

    jtcop_snd_romarb #(.PCM_OFFSET(22'h3FFFFF)) u_wrap (
        .clk(clk), .rst(rst), .cpu_cs(1'b0), .cpu_addr(16'h0), .cpu_data(w_cpu_data),
        .cpu_ok(w_cpu_ok), .pcm_cs(w_pcm_cs), .pcm_addr(w_pcm_addr), .pcm_data(w_pcm_data),
        .pcm_ok(w_pcm_ok), .sdr_addr(w_sdr_addr), .sdr_rd(w_sdr_rd), .sdr_ack(1'b0),
        .sdr_dst(1'b0), .sdr_din(16'h0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack;
        sdr_ack = 1;
        tick;
        sdr_ack = 0;
    endtask

    task automatic pulse_dst(input logic [15:0] d);
        sdr_din = d;
        sdr_dst = 1;
        tick;
        sdr_dst = 0;
    endtask

    function automatic logic [15:0] mem(input logic [21:0] a);
        return 16'(a * 22'h2F1) ^ 16'h5AC3;
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

    task automatic random_trial;
        logic cm, pm, gp;
        logic [21:0] ea;
        cpu_cs   = $urandom_range(0, 3) != 0;
        pcm_cs   = $urandom_range(0, 3) != 0;
        cpu_addr = 16'($urandom_range(0, 15)) | ($urandom_range(0, 3) == 0 ? 16'h8000 : 16'h0);
        pcm_addr = 18'($urandom_range(0, 15)) | ($urandom_range(0, 3) == 0 ? 18'h3FFF0 : 18'h0);
        for (int k = 0; k < 4; k++) begin
            cm = cpu_cs && !(mv[0] && mt[0] == {2'd0, cpu_addr[15:1]});
            pm = pcm_cs && !(mv[1] && mt[1] == pcm_addr[17:1]);
            if (!cm && !pm) break;
            gp = pm && (!cm || !last_pcm);
            ea = gp ? 22'h08000 + 22'(pcm_addr[17:1]) : 22'(cpu_addr[15:1]);
            for (int w = 0; w < 6 && !sdr_rd; w++) tick;
            check("rnd_rd", 32'(sdr_rd), 1);
            check("rnd_addr", 32'(sdr_addr), 32'(ea));
            repeat ($urandom_range(0, 2)) tick;
            pulse_ack;
            repeat ($urandom_range(0, 2)) tick;
            pulse_dst(mem(ea));
            mv[gp] = 1;
            mt[gp] = gp ? pcm_addr[17:1] : {2'd0, cpu_addr[15:1]};
            md[gp] = mem(ea);
            last_pcm = gp;
        end
        tick;
        check("rnd_cpu_ok", 32'(cpu_ok), 32'(cpu_cs));
        check("rnd_pcm_ok", 32'(pcm_ok), 32'(pcm_cs));
        check("rnd_idle", 32'(sdr_rd), 0);
        if (cpu_cs) check("rnd_cpu_data", 32'(cpu_data), 32'(pick(md[0], cpu_addr[0])));
        if (pcm_cs) check("rnd_pcm_data", 32'(pcm_data), 32'(pick(md[1], pcm_addr[0])));
    endtask

    initial begin
        tick;
        tick;
        check("rst_cpu_ok", 32'(cpu_ok), 0);
        check("rst_pcm_ok", 32'(pcm_ok), 0);
        check("rst_rd", 32'(sdr_rd), 0);
        check("rst_addr", 32'(sdr_addr), 0);
        check("rst_cpu_data", 32'(cpu_data), 0);
        check("rst_pcm_data", 32'(pcm_data), 0);
        rst = 0;

        w_pcm_cs = 1;
        w_pcm_addr = 18'h00002;
        cpu_cs = 1;
        cpu_addr = 16'h0123;
        tick;
        check("wrap_addr", 32'(w_sdr_addr), 0);
        check("miss_rd", 32'(sdr_rd), 1);
        check("miss_addr", 32'(sdr_addr), 32'h91);
        pulse_ack;
        check("rd_drop", 32'(sdr_rd), 0);
        pulse_dst(16'hA55A);
        check("miss_ok_c3", 32'(cpu_ok), 0);
        tick;
        check("miss_ok_c4", 32'(cpu_ok), 1);
        check("miss_data", 32'(cpu_data), 32'hA5);

        cpu_addr = 16'h0122;
        tick;
        check("hit_ok", 32'(cpu_ok), 1);
        check("hit_data", 32'(cpu_data), 32'h5A);
        check("hit_no_rd", 32'(sdr_rd), 0);
        cpu_cs = 0;
        tick;
        check("cs_drop_ok", 32'(cpu_ok), 0);

        cpu_cs = 1;
        cpu_addr = 16'h0010;
        tick;
        check("abort_addr1", 32'(sdr_addr), 32'h8);
        pulse_ack;
        cpu_addr = 16'h0200;
        pulse_dst(16'h1111);
        check("abort_ok1", 32'(cpu_ok), 0);
        tick;
        check("abort_rd2", 32'(sdr_rd), 1);
        check("abort_addr2", 32'(sdr_addr), 32'h100);
        check("abort_ok2", 32'(cpu_ok), 0);
        pulse_ack;
        pulse_dst(16'h2222);
        check("abort_ok3", 32'(cpu_ok), 0);
        tick;
        check("abort_ok4", 32'(cpu_ok), 1);
        check("abort_data", 32'(cpu_data), 32'h22);

        cpu_addr = 16'h0300;
        tick;
        pulse_ack;
        rst = 1;
        cpu_cs = 0;
        tick;
        rst = 0;
        pulse_dst(16'hDEAD);
        check("rstw_cpu_ok", 32'(cpu_ok), 0);
        check("rstw_pcm_ok", 32'(pcm_ok), 0);
        cpu_cs = 1;
        tick;
        check("rstw_nofill", 32'(cpu_ok), 0);
        check("rstw_rereq", 32'(sdr_rd), 1);
        rst = 1;
        cpu_cs = 0;
        tick;
        rst = 0;

        cpu_cs = 1;
        pcm_cs = 1;
        cpu_addr = 16'h0300;
        pcm_addr = 18'h00456;
        tick;
        check("tie1_cpu", 32'(sdr_addr), 32'h180);
        pulse_ack;
        cpu_addr = 16'h0500;
        pulse_dst(16'h1234);
        tick;
        check("tie2_pcm", 32'(sdr_addr), 32'h0822B);
        pulse_ack;
        pulse_dst(16'h5678);
        tick;
        check("tie2_pcm_ok", 32'(pcm_ok), 1);
        check("tie2_pcm_data", 32'(pcm_data), 32'h78);
        check("tie3_cpu", 32'(sdr_addr), 32'h280);
        pulse_ack;
        pulse_dst(16'h9ABC);
        tick;
        check("tie3_cpu_ok", 32'(cpu_ok), 1);
        check("tie3_cpu_data", 32'(cpu_data), 32'hBC);

        rst = 1;
        cpu_cs = 0;
        pcm_cs = 0;
        tick;
        rst = 0;
        mv[0] = 0;
        mv[1] = 0;
        mt[0] = 0;
        mt[1] = 0;
        md[0] = 0;
        md[1] = 0;
        last_pcm = 1;
        for (int t = 0; t < 150; t++) random_trial;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtcop_snd_romarb.md
JTCOP_SND_ROMARB -- requirements
Module: jtcop_snd_romarb

Interface
REQ-001 Parameters: CPU_OFFSET, default 22'h0, SDRAM word base of sound CPU ROM; PCM_OFFSET, default 22'h08000, SDRAM word base of ADPCM ROM.
REQ-002 Ports: clk in 1 system clock (24 MHz); rst in 1 reset, synchronous, active-high.
REQ-003 Ports: cpu_cs in 1 CPU ROM select; cpu_addr in 16 byte address; cpu_data out 8 read byte; cpu_ok out 1 data valid for current cpu_addr.
REQ-004 Ports: pcm_cs in 1 ADPCM select; pcm_addr in 18 byte address; pcm_data out 8 read byte; pcm_ok out 1 data valid for current pcm_addr.
REQ-005 Ports: sdr_addr out 22 word address; sdr_rd out 1 read request; sdr_ack in 1 request accepted; sdr_dst in 1 data strobe; sdr_din in 16 read word.

Function
REQ-006 Each requester SHALL own a one-word cache: tag (word address = byte address >> 1), 16-bit data, valid bit.
REQ-007 Hit = cs high, valid set, tag equal to current word address; on hit, ok SHALL assert the cycle after cs/address become stable and stay high while the hit holds.
REQ-008 Byte select: data = cache[15:8] if addr[0]=1, else cache[7:0].
REQ-009 ok SHALL deassert combinationally-registered within 1 cycle of cs falling or address leaving the cached word.
REQ-010 Miss with cs high = pending request for that requester.
REQ-011 FSM states: IDLE, REQ, WAIT; IDLE -> REQ when any request pending; REQ -> WAIT on sdr_ack; WAIT -> IDLE on sdr_dst.
REQ-012 In REQ, sdr_rd SHALL be high and sdr_addr stable until sdr_ack; sdr_rd SHALL drop the cycle after sdr_ack.
REQ-013 sdr_addr = CPU_OFFSET + cpu_addr[15:1] or PCM_OFFSET + pcm_addr[17:1], 22-bit add, modulo 2^22 wrap.
REQ-014 Grant latched on IDLE->REQ; grant and word address SHALL be frozen until return to IDLE.
REQ-015 Arbitration: single pending wins; both pending -> requester not served last (round-robin); after reset last-served = PCM, so CPU wins first tie.
REQ-016 On sdr_dst, sdr_din SHALL load the granted cache, tag = frozen address, valid=1.
REQ-017 Address change or cs drop during REQ/WAIT: transaction SHALL complete, cache filled with frozen address; new address re-evaluated in IDLE (no abort).
REQ-018 Minimum miss latency: cs high to ok high = 4 cycles given sdr_ack and sdr_dst each one cycle after prior event.
REQ-019 sdr_dst outside WAIT and sdr_ack outside REQ SHALL be ignored.
REQ-020 Worst-case CPU wait SHALL be bounded by one PCM transaction plus own transaction.

Reset
REQ-021 On rst: state IDLE, sdr_rd=0, sdr_addr=0, both valid=0, cpu_ok=0, pcm_ok=0, cpu_data=0, pcm_data=0, last-served=PCM.
REQ-022 rst mid-transaction SHALL abandon it; a later stray sdr_dst SHALL not fill any cache.

Structure
REQ-023 State encoding and offset defaults SHALL live in shared package jtcop_snd_pkg.
REQ-024 One sub-module jtcop_snd_romcache instantiated twice (tag/data/valid/hit/byte select), parameterised on address width.

Verification
REQ-025 CPU miss: cpu_cs=1, cpu_addr=16'h0123, ack/dst next-cycle, sdr_din=16'hA55A -> sdr_addr=22'h000091, cpu_data=8'hA5, cpu_ok at cycle 4.
REQ-026 Hit: then cpu_addr=16'h0122 -> no sdr_rd, cpu_data=8'h5A, cpu_ok within 1 cycle.
REQ-027 Tie: both miss same cycle after reset -> CPU served first, PCM second (sdr_addr=22'h08000+pcm_addr[17:1]); next tie -> PCM first.
REQ-028 Abort-free: cpu_addr changes 16'h0010->16'h0200 during WAIT -> first fill tag 22'h8, then second request 22'h100; cpu_ok only for matching data.
REQ-029 Wrap: PCM_OFFSET=22'h3FFFFF, pcm_addr=18'h00002 -> sdr_addr=22'h000000.
REQ-030 Reset in WAIT, then sdr_dst -> no valid set, cpu_ok/pcm_ok stay 0, state IDLE.
